// File: rtl/mmp_iddmm_pkg.sv
// Shared types and constants for the IDDMM loader front end.
// The enum encodes the job sequencer states; WR_ALL enables all three operand RAMs.
package mmp_iddmm_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    START = 3'd2,
    RUN   = 3'd3,
    DRAIN = 3'd4
  } state_t;

  localparam logic [2:0] WR_ALL = 3'b111;

  // Operand beats can only be taken while a job is being loaded.
  function automatic logic is_loading(input state_t s);
    return (s == IDLE) || (s == LOAD);
  endfunction

endpackage

// File: rtl/mmp_iddmm_loader_if.sv
// Operand input stream and result output stream of the IDDMM loader.
// Both streams: a beat transfers on a rising edge where valid && ready; a pending beat keeps its payload stable.
interface mmp_iddmm_loader_if #(
  parameter int K = 128
);

  logic         s_valid;
  logic         s_ready;
  logic [K-1:0] s_x;
  logic [K-1:0] s_y;
  logic [K-1:0] s_m;
  logic [K-1:0] s_m1;
  logic         s_last;

  logic         m_valid;
  logic         m_ready;
  logic [K-1:0] m_data;
  logic         m_last;

  modport master (
    output s_valid, s_x, s_y, s_m, s_m1, s_last,
    input  s_ready,
    input  m_valid, m_data, m_last,
    output m_ready
  );

  modport slave (
    input  s_valid, s_x, s_y, s_m, s_m1, s_last,
    output s_ready,
    output m_valid, m_data, m_last,
    input  m_ready
  );

endinterface

// File: rtl/mmp_iddmm_resbuf.sv
// N x K result capture buffer: one write port fed by multiplier grants, one async read port for replay.
// Contents are not reset; the reader only looks at entries written in the current job.
module mmp_iddmm_resbuf #(
  parameter int K      = 128,
  parameter int N      = 16,
  parameter int ADDR_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [K-1:0]      wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [K-1:0]      rd_data
);

  logic [K-1:0] mem_q [N];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/mmp_iddmm_loader.sv
// Job sequencer in front of mmp_iddmm_sp: loads x/y/m RAMs, fires task_req, buffers and replays results.
// Define MMP_IDDMM_LOADER_LAST_CHK_EN to check s_last against the beat count and abort bad jobs.
module mmp_iddmm_loader
  import mmp_iddmm_pkg::*;
#(
  parameter int K      = 128,
  parameter int N      = 16,
  parameter int ADDR_W = $clog2(N)
) (
  input  logic              clk,
  input  logic              rst_n,
  mmp_iddmm_loader_if.slave bus,
  output logic [2:0]        mm_wr_ena,
  output logic [ADDR_W-1:0] mm_wr_addr,
  output logic [K-1:0]      mm_wr_x,
  output logic [K-1:0]      mm_wr_y,
  output logic [K-1:0]      mm_wr_m,
  output logic [K-1:0]      mm_wr_m1,
  output logic              mm_task_req,
  input  logic              mm_task_grant,
  input  logic [K-1:0]      mm_task_res,
  input  logic              mm_task_end,
  output logic              busy,
  output logic              err_len,
  output state_t            dbg_state
);

  localparam int                CW       = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N - 1);
  localparam logic [CW-1:0]     RES_MAX  = CW'(N);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] wcnt_q, wcnt_d;
  logic [CW-1:0]     rcnt_q, rcnt_d;
  logic [ADDR_W-1:0] ocnt_q, ocnt_d;
  logic              s_ready_q, s_ready_d;
  logic [2:0]        wr_ena_q, wr_ena_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [K-1:0]      wr_x_q, wr_x_d;
  logic [K-1:0]      wr_y_q, wr_y_d;
  logic [K-1:0]      wr_m_q, wr_m_d;
  logic [K-1:0]      wr_m1_q, wr_m1_d;
  logic              task_req_q, task_req_d;

  logic              accept;
  logic              beat_is_last;
  logic              len_bad;
  logic              grant_keep;
  logic              m_valid;
  logic              m_fire;
  logic              rd_last;
  logic [CW-1:0]     rcnt_m1;
  logic [K-1:0]      rd_data;

  assign accept       = bus.s_valid && s_ready_q && is_loading(state_q);
  assign beat_is_last = (wcnt_q == LAST_IDX);
  // Grants past the N-th have no buffer slot and are dropped.
  assign grant_keep   = (state_q == RUN) && mm_task_grant && (rcnt_q < RES_MAX);
  assign m_valid      = (state_q == DRAIN);
  assign m_fire       = m_valid && bus.m_ready;
  assign rcnt_m1      = rcnt_q - CW'(1);
  assign rd_last      = ({1'b0, ocnt_q} == rcnt_m1);

`ifdef MMP_IDDMM_LOADER_LAST_CHK_EN
  logic err_q, err_d;

  assign len_bad = accept && (bus.s_last != beat_is_last);

  always_comb begin
    err_d = err_q | len_bad;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err_len = err_q;
`else
  logic unused_s_last;

  assign unused_s_last = bus.s_last;
  assign len_bad       = 1'b0;
  assign err_len       = 1'b0;
`endif

  mmp_iddmm_resbuf #(
    .K      (K),
    .N      (N),
    .ADDR_W (ADDR_W)
  ) u_resbuf (
    .clk     (clk),
    .wr_en   (grant_keep),
    .wr_addr (rcnt_q[ADDR_W-1:0]),
    .wr_data (mm_task_res),
    .rd_addr (ocnt_q),
    .rd_data (rd_data)
  );

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    rcnt_d  = rcnt_q;
    ocnt_d  = ocnt_q;
    case (state_q)
      IDLE, LOAD: begin
        if (accept) begin
          if (len_bad) begin
            state_d = IDLE;
            wcnt_d  = '0;
          end else if (beat_is_last) begin
            state_d = START;
            wcnt_d  = '0;
          end else begin
            state_d = LOAD;
            wcnt_d  = wcnt_q + ADDR_W'(1);
          end
        end
      end
      START: begin
        state_d = RUN;
        rcnt_d  = '0;
      end
      RUN: begin
        if (grant_keep) begin
          rcnt_d = rcnt_q + CW'(1);
        end
        // A grant coinciding with end is already counted in rcnt_d.
        if (mm_task_end) begin
          ocnt_d  = '0;
          state_d = (rcnt_d == '0) ? IDLE : DRAIN;
        end
      end
      DRAIN: begin
        if (m_fire) begin
          if (rd_last) begin
            state_d = IDLE;
            ocnt_d  = '0;
            rcnt_d  = '0;
          end else begin
            ocnt_d = ocnt_q + ADDR_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    wr_ena_d  = accept ? WR_ALL : 3'b000;
    wr_addr_d = wr_addr_q;
    wr_x_d    = wr_x_q;
    wr_y_d    = wr_y_q;
    wr_m_d    = wr_m_q;
    wr_m1_d   = wr_m1_q;
    if (accept) begin
      wr_addr_d = wcnt_q;
      wr_x_d    = bus.s_x;
      wr_y_d    = bus.s_y;
      wr_m_d    = bus.s_m;
      wr_m1_d   = bus.s_m1;
    end
    // Registered from START so the request trails the final RAM write by one cycle.
    task_req_d = (state_q == START);
    s_ready_d  = is_loading(state_d);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      wcnt_q     <= '0;
      rcnt_q     <= '0;
      ocnt_q     <= '0;
      s_ready_q  <= 1'b0;
      wr_ena_q   <= 3'b000;
      wr_addr_q  <= '0;
      wr_x_q     <= '0;
      wr_y_q     <= '0;
      wr_m_q     <= '0;
      wr_m1_q    <= '0;
      task_req_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      rcnt_q     <= rcnt_d;
      ocnt_q     <= ocnt_d;
      s_ready_q  <= s_ready_d;
      wr_ena_q   <= wr_ena_d;
      wr_addr_q  <= wr_addr_d;
      wr_x_q     <= wr_x_d;
      wr_y_q     <= wr_y_d;
      wr_m_q     <= wr_m_d;
      wr_m1_q    <= wr_m1_d;
      task_req_q <= task_req_d;
    end
  end

  assign bus.s_ready = s_ready_q;
  assign bus.m_valid = m_valid;
  assign bus.m_data  = m_valid ? rd_data : '0;
  assign bus.m_last  = m_valid && rd_last;

  assign mm_wr_ena   = wr_ena_q;
  assign mm_wr_addr  = wr_addr_q;
  assign mm_wr_x     = wr_x_q;
  assign mm_wr_y     = wr_y_q;
  assign mm_wr_m     = wr_m_q;
  assign mm_wr_m1    = wr_m1_q;
  assign mm_task_req = task_req_q;
  assign busy        = (state_q != IDLE);
  assign dbg_state   = state_q;

endmodule

// File: doc/mmp_iddmm_loader.md
# mmp_iddmm_loader

Front-end job sequencer for the IDDMM Montgomery multiplier (`mmp_iddmm_sp`). It accepts one job as a stream of N operand beats, each carrying x, y and m limbs plus m1. It writes those beats into the multiplier's x/y/m RAMs and issues `task_req`. It then captures the N result limbs the multiplier emits (it has no backpressure) into a local buffer and replays them on a valid/ready output stream.

## Interface
Parameters:
- `K`, 128: limb width in bits.
- `N`, 16: limbs per operand.
- `ADDR_W`, `$clog2(N)`: limb address width.

Ports:
- `clk` in 1: single clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `s_valid` in 1: operand beat valid.
- `s_ready` out 1: operand beat accept.
- `s_x`, `s_y`, `s_m` in K each: limb j of x, y, m, sent low limb first.
- `s_m1` in K: m1, held constant for the whole job.
- `s_last` in 1: marks beat N-1.
- `mm_wr_ena` out 3: RAM write enables, {m, y, x}.
- `mm_wr_addr` out ADDR_W: RAM write address.
- `mm_wr_x`, `mm_wr_y`, `mm_wr_m`, `mm_wr_m1` out K each: RAM write data.
- `mm_task_req` out 1: start pulse to the multiplier.
- `mm_task_grant` in 1: result limb valid.
- `mm_task_res` in K: result limb.
- `mm_task_end` in 1: multiplier done pulse.
- `m_valid` out 1, `m_ready` in 1, `m_data` out K, `m_last` out 1: result stream, low limb first.
- `busy` out 1: high in any state except IDLE.
- `err_len` out 1: sticky length error.

## Operation
FSM states: IDLE, LOAD, START, RUN, DRAIN.
- **IDLE:** `s_ready` = 1. An accepted beat (`s_valid && s_ready`) writes limb 0 and moves to LOAD with beat counter `wcnt` = 1.
- **LOAD:** `s_ready` = 1. Each accepted beat writes limb `wcnt` and increments `wcnt`. When the beat with `wcnt` = N-1 is accepted, go to START.
- **Write path:** registered. `mm_wr_ena` = 3'b111, `mm_wr_addr` = `wcnt`, and the data are driven for exactly one cycle after each accept. `mm_wr_ena` is 0 otherwise.
- **START:** `s_ready` = 0. `mm_task_req` = 1 for exactly one cycle, then go to RUN with `rcnt` = 0.
- **RUN:** on each `mm_task_grant`, store `mm_task_res` at `buf[rcnt]` and increment `rcnt`. Grants beyond N are dropped. On `mm_task_end`, go to DRAIN. A grant in the same cycle as `mm_task_end` is stored first.
- **DRAIN:** `m_valid` = 1 and `m_data` = `buf[ocnt]`. `m_last` = 1 when `ocnt` = `rcnt`-1. A handshake increments `ocnt`; the handshake with `m_last` returns to IDLE. If `rcnt` = 0 at entry, go directly to IDLE.
- `m_data` is stable while `m_valid && !m_ready`.
- The buffer is N×K, registers or LUT RAM.
- A new job is never accepted before the result stream is fully drained.

## Timing
- Reset values:
  - State IDLE.
  - `s_ready` = 0 during reset, 1 on the first cycle after.
  - `mm_wr_ena` = 0, `mm_wr_addr` = 0, `mm_wr_*` = 0, `mm_task_req` = 0.
  - `m_valid` = 0, `m_last` = 0, `m_data` = 0.
  - `busy` = 0, `err_len` = 0, all counters 0.
- Beat accepted at cycle t: RAM write at t+1.
- Last beat accepted at t_L: last write at t_L+1, `mm_task_req` at t_L+2. This guarantees writes land before the request.
- First `m_valid` occurs one cycle after `mm_task_end` is sampled.
- Best-case job: N load cycles + 2 + multiplier time + N drain cycles.
- Reset asserted mid-job: everything returns to reset values immediately. RAM contents are undefined, and no `mm_task_req` is issued until a fresh full job arrives.

## Configuration
- **`MMP_IDDMM_LOADER_LAST_CHK_EN` defined:**
  - If `s_last` = 1 on a beat with `wcnt` ≠ N-1, or `s_last` = 0 on beat N-1, then `err_len` is set and sticky until reset.
  - The job is aborted: return to IDLE, no `mm_task_req`. Beats already written remain in RAM.
- **Macro undefined:** `s_last` is ignored, the beat count alone ends the load, and `err_len` is tied to 0.

## Structure
- Shared package `mmp_iddmm_pkg` holds:
  - the state enum (`IDLE`, `LOAD`, `START`, `RUN`, `DRAIN`);
  - the `WR_ALL` = 3'b111 constant.
- Natural sub-module: `mmp_iddmm_resbuf`, the N×K capture buffer with a write port (grant side) and a read port (`ocnt` side).
- The loader instantiates `mmp_iddmm_sp` only in the bench, not inside this block.

## Test plan
- **Normal job:** N=16 beats, x=1, y=1, m=odd, `m_ready`=1 → 16 writes at addresses 0..15 with `mm_wr_ena`=7, one `mm_task_req` 2 cycles after the last accept, 16 results out with `m_last` on the 16th, matching the golden model for x·y·R⁻¹ mod m.
- **Output backpressure:** toggle `m_ready` 1 cycle on, 2 off → `m_data` holds while stalled, all 16 limbs arrive in order, and `s_ready` stays 0 until the final handshake.
- **Input gaps:** `s_valid` with random bubbles → `wcnt` advances only on accept, addresses stay contiguous, exactly one `mm_task_req`.
- **Extra grant:** stub multiplier emits 17 grants then end → only the first 16 are output, 16 `m_valid` handshakes.
- **Reset mid-run:** `rst_n` low during RUN at limb 5 → all outputs go to reset values asynchronously; a following full job completes correctly.
- **`MMP_IDDMM_LOADER_LAST_CHK_EN` defined:** `s_last` asserted on beat 3 → `err_len`=1, no `mm_task_req`, `s_ready`=1 the next cycle.
